// File: rtl/wrapping_fifo.sv
// Synchronous FIFO for any DEPTH >= 2; pointers wrap DEPTH-1 -> 0, and an occupancy counter drives full, empty and level.
// Latency: a written word appears on read_data (first-word-fall-through) the next cycle; there is no bypass when the FIFO is empty.
// Backpressure: a write is dropped while full and a read is ignored while empty. Optional sticky error flags: WRAPPING_FIFO_ERROR_FLAGS_EN.
module wrapping_fifo #(
    parameter int WIDTH       = 8,
    parameter int DEPTH       = 5,
    parameter int DEPTH_LOG2  = $clog2(DEPTH),
    parameter int LEVEL_WIDTH = $clog2(DEPTH + 1)
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic                   write_enable,
    input  logic [WIDTH-1:0]       write_data,
    output logic                   full,
    input  logic                   read_enable,
    output logic [WIDTH-1:0]       read_data,
    output logic                   empty,
    output logic [LEVEL_WIDTH-1:0] level
`ifdef WRAPPING_FIFO_ERROR_FLAGS_EN
    ,
    output logic                   overflow,
    output logic                   underflow
`endif
);

    localparam logic [DEPTH_LOG2-1:0]  PTR_LAST = DEPTH_LOG2'(DEPTH - 1);
    localparam logic [DEPTH_LOG2-1:0]  PTR_ONE  = DEPTH_LOG2'(1);
    localparam logic [LEVEL_WIDTH-1:0] LVL_FULL = LEVEL_WIDTH'(DEPTH);
    localparam logic [LEVEL_WIDTH-1:0] LVL_ONE  = LEVEL_WIDTH'(1);

    logic [WIDTH-1:0]       mem_q [DEPTH];
    logic [DEPTH_LOG2-1:0]  wr_ptr_q, wr_ptr_d;
    logic [DEPTH_LOG2-1:0]  rd_ptr_q, rd_ptr_d;
    logic [LEVEL_WIDTH-1:0] level_q, level_d;
    logic                   wr_accept;
    logic                   rd_accept;

    // Accept decisions, wrapping pointer advance and occupancy update
    always_comb begin
        wr_accept = write_enable && !full;
        rd_accept = read_enable && !empty;

        wr_ptr_d = wr_ptr_q;
        if (wr_accept) begin
            wr_ptr_d = (wr_ptr_q == PTR_LAST) ? '0 : wr_ptr_q + PTR_ONE;
        end

        rd_ptr_d = rd_ptr_q;
        if (rd_accept) begin
            rd_ptr_d = (rd_ptr_q == PTR_LAST) ? '0 : rd_ptr_q + PTR_ONE;
        end

        level_d = level_q;
        case ({wr_accept, rd_accept})
            2'b10:   level_d = level_q + LVL_ONE;
            2'b01:   level_d = level_q - LVL_ONE;
            default: level_d = level_q;
        endcase
    end

    // Pointer and occupancy registers; reset wins over any same-cycle request
    always_ff @(posedge clock) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
        end
    end

    // Storage array; contents are deliberately left unreset
    always_ff @(posedge clock) begin
        if (wr_accept && !reset) begin
            mem_q[wr_ptr_q] <= write_data;
        end
    end

    assign full      = (level_q == LVL_FULL);
    assign empty     = (level_q == '0);
    assign level     = level_q;
    assign read_data = mem_q[rd_ptr_q];

`ifdef WRAPPING_FIFO_ERROR_FLAGS_EN
    logic overflow_q, overflow_d;
    logic underflow_q, underflow_d;

    // Sticky flags latch any rejected request until the next reset
    always_comb begin
        overflow_d  = overflow_q  || (write_enable && full);
        underflow_d = underflow_q || (read_enable && empty);
    end

    // Error flag registers
    always_ff @(posedge clock) begin
        if (reset) begin
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            overflow_q  <= overflow_d;
            underflow_q <= underflow_d;
        end
    end

    assign overflow  = overflow_q;
    assign underflow = underflow_q;
`endif

endmodule

// File: tb/tb_wrapping_fifo.sv
// Bench for wrapping_fifo at DEPTH=5, WIDTH=8: directed scenarios with literal expectations plus randomized traffic.
// A queue-based model is checked against the DUT outputs on every falling edge.
// The sticky overflow/underflow flags are also checked when WRAPPING_FIFO_ERROR_FLAGS_EN is defined.
module tb_wrapping_fifo;

    localparam int WIDTH = 8;
    localparam int DEPTH = 5;
    localparam int LW    = $clog2(DEPTH + 1);

    logic             clock = 1'b0;
    logic             reset = 1'b1;
    logic             write_enable = 1'b0;
    logic [WIDTH-1:0] write_data = '0;
    logic             read_enable = 1'b0;
    logic             full;
    logic             empty;
    logic [WIDTH-1:0] read_data;
    logic [LW-1:0]    level;
`ifdef WRAPPING_FIFO_ERROR_FLAGS_EN
    logic             overflow;
    logic             underflow;
`endif

    int errors = 0;
    int checks = 0;

    wrapping_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
        .clock        (clock),
        .reset        (reset),
        .write_enable (write_enable),
        .write_data   (write_data),
        .full         (full),
        .read_enable  (read_enable),
        .read_data    (read_data),
        .empty        (empty),
        .level        (level)
`ifdef WRAPPING_FIFO_ERROR_FLAGS_EN
        ,
        .overflow     (overflow),
        .underflow    (underflow)
`endif
    );

    always #5 clock = ~clock;

    // Reference model: a plain queue plus sticky error bits
    logic [WIDTH-1:0] mq[$];
    bit               m_ovf = 1'b0;
    bit               m_unf = 1'b0;
    bit               model_ok = 1'b0;
    bit               m_do_w;
    bit               m_do_r;

    always @(posedge clock) begin
        if (reset) begin
            mq.delete();
            m_ovf    = 1'b0;
            m_unf    = 1'b0;
            model_ok = 1'b1;
        end else begin
            m_do_w = write_enable && (mq.size() < DEPTH);
            m_do_r = read_enable && (mq.size() > 0);
            if (write_enable && mq.size() == DEPTH) m_ovf = 1'b1;
            if (read_enable && mq.size() == 0) m_unf = 1'b1;
            if (m_do_r) void'(mq.pop_front());
            if (m_do_w) mq.push_back(write_data);
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Every-cycle comparison of the DUT outputs against the model
    always @(negedge clock) begin
        if (model_ok) begin
            chk("model_level", 32'(level), 32'(mq.size()));
            chk("model_empty", 32'(empty), 32'(mq.size() == 0));
            chk("model_full", 32'(full), 32'(mq.size() == DEPTH));
            if (mq.size() > 0) chk("model_data", 32'(read_data), 32'(mq[0]));
`ifdef WRAPPING_FIFO_ERROR_FLAGS_EN
            chk("model_overflow", 32'(overflow), 32'(m_ovf));
            chk("model_underflow", 32'(underflow), 32'(m_unf));
`endif
        end
    end

    // One clock cycle: drive the inputs, then return at the following falling edge
    task automatic cyc(input logic we, input logic [WIDTH-1:0] wd, input logic re);
        write_enable = we;
        write_data   = wd;
        read_enable  = re;
        @(posedge clock);
        @(negedge clock);
        write_enable = 1'b0;
        read_enable  = 1'b0;
    endtask

    int d;
    int e;

    initial begin
        @(negedge clock);
        reset = 1'b1;
        cyc(0, 0, 0);
        cyc(0, 0, 0);
        reset = 1'b0;
        cyc(0, 0, 0);
        chk("reset_empty", 32'(empty), 1);
        chk("reset_full", 32'(full), 0);
        chk("reset_level", 32'(level), 0);
`ifdef WRAPPING_FIFO_ERROR_FLAGS_EN
        chk("reset_ovf", 32'(overflow), 0);
        chk("reset_unf", 32'(underflow), 0);
`endif

        // Fill to capacity, drop a sixth write, then drain in order
        for (int i = 0; i < DEPTH; i++) begin
            cyc(1, 8'(8'h11 * (i + 1)), 0);
            chk("fill_level", 32'(level), 32'(i + 1));
        end
        chk("fill_full", 32'(full), 1);
        cyc(1, 8'h66, 0);
        chk("drop_level", 32'(level), 5);
`ifdef WRAPPING_FIFO_ERROR_FLAGS_EN
        chk("ovf_set", 32'(overflow), 1);
`endif
        for (int i = 0; i < DEPTH; i++) begin
            chk("drain_data", 32'(read_data), 32'(8'h11 * (i + 1)));
            cyc(0, 0, 1);
        end
        chk("drain_empty", 32'(empty), 1);
        chk("drain_level", 32'(level), 0);

        // Pointer wrap: 7 rounds of write-3/read-3
        d = 0;
        e = 0;
        for (int r = 0; r < 7; r++) begin
            for (int k = 0; k < 3; k++) begin
                cyc(1, 8'(d), 0);
                d++;
            end
            chk("wrap_level", 32'(level), 3);
            for (int k = 0; k < 3; k++) begin
                chk("wrap_data", 32'(read_data), 32'(e));
                cyc(0, 0, 1);
                e++;
            end
        end
        chk("wrap_count", 32'(e), 21);
        chk("wrap_empty", 32'(empty), 1);

        // Full with both requests: the read proceeds and the write is dropped
        for (int i = 0; i < DEPTH; i++) cyc(1, 8'(8'hB0 + i), 0);
        chk("fullrw_pre_full", 32'(full), 1);
        chk("fullrw_head", 32'(read_data), 32'hB0);
        cyc(1, 8'hEE, 1);
        chk("fullrw_level", 32'(level), 4);
        chk("fullrw_full", 32'(full), 0);
        for (int i = 1; i < DEPTH; i++) begin
            chk("fullrw_data", 32'(read_data), 32'(8'hB0 + i));
            cyc(0, 0, 1);
        end
        chk("fullrw_empty", 32'(empty), 1);

        // Empty with both requests: the write proceeds and the read is ignored
        cyc(1, 8'hA5, 1);
        chk("emptyrw_empty", 32'(empty), 0);
        chk("emptyrw_data", 32'(read_data), 32'hA5);
        chk("emptyrw_level", 32'(level), 1);
`ifdef WRAPPING_FIFO_ERROR_FLAGS_EN
        chk("unf_set", 32'(underflow), 1);
        cyc(0, 0, 0);
        chk("unf_sticky", 32'(underflow), 1);
        chk("ovf_sticky", 32'(overflow), 1);
`endif
        cyc(0, 0, 1);

        // Reset mid-stream with three words buffered, alongside both requests
        cyc(1, 8'h01, 0);
        cyc(1, 8'h02, 0);
        cyc(1, 8'h03, 0);
        chk("midrst_pre", 32'(level), 3);
        reset = 1'b1;
        cyc(1, 8'h04, 1);
        reset = 1'b0;
        chk("midrst_level", 32'(level), 0);
        chk("midrst_empty", 32'(empty), 1);
`ifdef WRAPPING_FIFO_ERROR_FLAGS_EN
        chk("midrst_ovf", 32'(overflow), 0);
        chk("midrst_unf", 32'(underflow), 0);
`endif

        // Randomized traffic with a fill/drain bias that changes per phase and occasional resets
        for (int p = 0; p < 8; p++) begin
            int wb;
            wb = (p % 2 == 0) ? 75 : 25;
            for (int n = 0; n < 300; n++) begin
                reset = ($urandom_range(0, 199) == 0);
                cyc($urandom_range(0, 99) < wb, 8'($urandom), $urandom_range(0, 99) >= wb);
            end
        end
        reset = 1'b0;
        cyc(0, 0, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
